// File: rtl/uart_msg_pkg.sv
// Shared types and sizing for the "abcd" message sequencer.
// A message is NUM_CHARS 8N1 frames (FRAME_BITS each), stepped through by a SEL_W-bit mux select.
package uart_msg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int SEL_W        = 6;
  localparam int FRAME_BITS   = 10;
  localparam int NUM_CHARS    = 4;
  localparam int BAUD_DIV_DEF = 139;
  localparam int LAST_SEL_DEF = NUM_CHARS * FRAME_BITS - 1;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud divider: counts 0..BAUD_DIV-1 while en, one-cycle tick at the terminal count.
// clr holds the count at zero so each message starts on a full bit period.
module baud_tick_gen
  import uart_msg_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W   = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_msg_seq.sv
// Steps the message mux select 0..LAST_SEL per start, registers the line (start->txd 2 clk), idle-high otherwise.
// Optional UART_MSG_SEQ_LOOP_EN: with start held at the last bit, wrap straight into the next message.
module uart_msg_seq
  import uart_msg_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int LAST_SEL = LAST_SEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             txd_in,
  output logic [SEL_W-1:0] sel,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST_SEL_V = SEL_W'(LAST_SEL);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last_bit;

  // Counter is held clear outside SEND so the first bit gets a full period.
  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q != SEND),
    .en  (state_q == SEND),
    .tick(tick)
  );

  assign last_bit = tick && (sel_q == LAST_SEL_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_bit) begin
`ifdef UART_MSG_SEQ_LOOP_EN
          state_d = start ? SEND : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d  = sel_q;
    txd_d  = 1'b1;
    done_d = 1'b0;
    busy   = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = '0;
      end
      SEND: begin
        busy   = 1'b1;
        txd_d  = txd_in;
        done_d = last_bit;
        if (tick) begin
          sel_d = last_bit ? '0 : sel_q + 1'b1;
        end
      end
      default: begin
        sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      txd_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      txd_q  <= txd_d;
      done_q <= done_d;
    end
  end

  assign sel  = sel_q;
  assign txd  = txd_q;
  assign done = done_q;

endmodule
